// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: per-channel square wave and tick,
// with divisor updates deferred to the period boundary and a global phase sync.
module prog_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 1000000,
    parameter int SEL_W       = 2
) (
    input  logic              iClk_in,
    input  logic              iRst,
    input  logic [NUM_CH-1:0] iEn,
    input  logic              iWe,
    input  logic [SEL_W-1:0]  iSel,
    input  logic [CNT_W-1:0]  iDiv,
    input  logic              iSync,
    output logic [NUM_CH-1:0] oClk_out,
    output logic [NUM_CH-1:0] oTick,
    output logic [NUM_CH-1:0] oPend
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  div_d  [NUM_CH];
    logic [CNT_W-1:0]  pdiv_q [NUM_CH];
    logic [CNT_W-1:0]  pdiv_d [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pend_q, pend_d;

    logic [CNT_W-1:0]  eff     [NUM_CH];
    logic [CNT_W-1:0]  thresh  [NUM_CH];
    logic [CNT_W-1:0]  cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] wr;

    // Divisors 0 and 1 run as 2; the high phase is the last E>>1 counts.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            eff[k]     = (div_q[k] < TWO) ? TWO : div_q[k];
            thresh[k]  = eff[k] - (eff[k] >> 1);
            wrap[k]    = (cnt_q[k] == eff[k] - ONE);
            cnt_inc[k] = wrap[k] ? '0 : cnt_q[k] + ONE;
            wr[k]      = iWe && (iSel == SEL_W'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            // A write on this edge bypasses pending so a same-edge apply sees it.
            pdiv_d[k] = wr[k] ? iDiv : pdiv_q[k];
            div_d[k]  = div_q[k];
            cnt_d[k]  = cnt_q[k];
            clk_d[k]  = 1'b0;
            tick_d[k] = 1'b0;
            pend_d[k] = pend_q[k] | wr[k];
            if (!iEn[k] || iSync) begin
                cnt_d[k]  = '0;
                div_d[k]  = pdiv_d[k];
                pend_d[k] = 1'b0;
            end else begin
                cnt_d[k]  = cnt_inc[k];
                clk_d[k]  = (cnt_inc[k] >= thresh[k]);
                tick_d[k] = wrap[k];
                if (wrap[k]) begin
                    div_d[k]  = pdiv_d[k];
                    pend_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iClk_in or negedge iRst) begin
        if (!iRst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k]  <= '0;
                div_q[k]  <= RST_DIV;
                pdiv_q[k] <= RST_DIV;
            end
            clk_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k]  <= cnt_d[k];
                div_q[k]  <= div_d[k];
                pdiv_q[k] <= pdiv_d[k];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign oClk_out = clk_q;
    assign oTick    = tick_q;
    assign oPend    = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (2 channels, 8-bit, default divisor 4),
// plus a 1-channel instance for the out-of-range select case.
module tb_prog_clock_divider;

    logic       clk;
    logic       iRst;
    logic [1:0] iEn;
    logic       iWe;
    logic       iSel;
    logic [7:0] iDiv;
    logic       iSync;
    logic [1:0] oClk_out;
    logic [1:0] oTick;
    logic [1:0] oPend;

    logic       en1;
    logic       we1;
    logic       sel1;
    logic [7:0] div1;
    logic       sync1;
    logic       clk1;
    logic       tick1;
    logic       pend1;

    int total;
    int bad;

    prog_clock_divider #(
        .NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4), .SEL_W(1)
    ) u_dut (
        .iClk_in (clk),
        .iRst    (iRst),
        .iEn     (iEn),
        .iWe     (iWe),
        .iSel    (iSel),
        .iDiv    (iDiv),
        .iSync   (iSync),
        .oClk_out(oClk_out),
        .oTick   (oTick),
        .oPend   (oPend)
    );

    prog_clock_divider #(
        .NUM_CH(1), .CNT_W(8), .DEFAULT_DIV(4), .SEL_W(1)
    ) u_one (
        .iClk_in (clk),
        .iRst    (iRst),
        .iEn     (en1),
        .iWe     (we1),
        .iSel    (sel1),
        .iDiv    (div1),
        .iSync   (sync1),
        .oClk_out(clk1),
        .oTick   (tick1),
        .oPend   (pend1)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        iRst = 1'b0; iEn = 2'b00; iWe = 1'b0; iSel = 1'b0; iDiv = '0; iSync = 1'b0;
        en1 = 1'b0; we1 = 1'b0; sel1 = 1'b0; div1 = '0; sync1 = 1'b0;
        #3;
        total++; if (oClk_out !== 2'b00) begin bad++; $display("FAIL reset_clk got=%b exp=00", oClk_out); end
        total++; if (oTick !== 2'b00) begin bad++; $display("FAIL reset_tick got=%b exp=00", oTick); end
        total++; if (oPend !== 2'b00) begin bad++; $display("FAIL reset_pend got=%b exp=00", oPend); end
        total++; if ({clk1, tick1, pend1} !== 3'b000) begin bad++; $display("FAIL reset_one got=%b exp=000", {clk1, tick1, pend1}); end
        step();
        iRst = 1'b1;
        step();
        total++; if (oClk_out !== 2'b00 || oTick !== 2'b00) begin bad++; $display("FAIL post_reset_idle got=%b%b exp=0000", oClk_out, oTick); end
    endtask

    task automatic test_basic();
        logic c;
        logic t;
        iEn = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            step();
            c = ((i % 4) >= 2);
            t = ((i % 4) == 0);
            total++; if (oClk_out !== {c, c}) begin bad++; $display("FAIL basic_clk i=%0d got=%b exp=%b", i, oClk_out, {c, c}); end
            total++; if (oTick !== {t, t}) begin bad++; $display("FAIL basic_tick i=%0d got=%b exp=%b", i, oTick, {t, t}); end
        end
    endtask

    task automatic test_div_change();
        logic c;
        logic t;
        step();
        iWe = 1'b1; iSel = 1'b0; iDiv = 8'd5;
        step();
        iWe = 1'b0;
        total++; if (oPend !== 2'b01) begin bad++; $display("FAIL div_pend_set got=%b exp=01", oPend); end
        step();
        total++; if (oPend[0] !== 1'b1 || oClk_out[0] !== 1'b1) begin bad++; $display("FAIL div_old_period got=%b%b exp=11", oPend[0], oClk_out[0]); end
        step();
        total++; if (oTick[0] !== 1'b1 || oPend[0] !== 1'b0 || oClk_out[0] !== 1'b0) begin bad++; $display("FAIL div_wrap got=%b%b%b exp=100", oTick[0], oPend[0], oClk_out[0]); end
        for (int j = 1; j <= 10; j++) begin
            step();
            c = ((j % 5) >= 3);
            t = ((j % 5) == 0);
            total++; if (oClk_out[0] !== c || oTick[0] !== t) begin bad++; $display("FAIL div5 j=%0d got=%b%b exp=%b%b", j, oClk_out[0], oTick[0], c, t); end
        end
        iEn = 2'b00;
        step();
    endtask

    task automatic test_small_div();
        for (int v = 0; v <= 1; v++) begin
            iWe = 1'b1; iSel = 1'b1; iDiv = 8'(v);
            step();
            iWe = 1'b0;
            total++; if (oPend !== 2'b00) begin bad++; $display("FAIL small_pend v=%0d got=%b exp=00", v, oPend); end
            iEn = 2'b10;
            for (int j = 1; j <= 6; j++) begin
                step();
                total++; if (oClk_out !== {(j % 2 == 1), 1'b0} || oTick !== {(j % 2 == 0), 1'b0})
                begin bad++; $display("FAIL small_div v=%0d j=%0d got=%b/%b exp=%b0/%b0", v, j, oClk_out, oTick, (j % 2 == 1), (j % 2 == 0)); end
            end
            iEn = 2'b00;
            step();
        end
    endtask

    task automatic test_sel_ignore();
        logic c;
        logic t;
        en1 = 1'b1;
        step();
        we1 = 1'b1; sel1 = 1'b1; div1 = 8'd2;
        step();
        we1 = 1'b0;
        total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL sel_pend got=%b exp=0", pend1); end
        for (int j = 2; j <= 9; j++) begin
            if (j > 2) step();
            c = ((j % 4) >= 2);
            t = ((j % 4) == 0);
            total++; if (clk1 !== c || tick1 !== t) begin bad++; $display("FAIL sel_ignore j=%0d got=%b%b exp=%b%b", j, clk1, tick1, c, t); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_sync();
        logic c0, c1, t0, t1;
        iWe = 1'b1; iSel = 1'b0; iDiv = 8'd6;
        step();
        iSel = 1'b1; iDiv = 8'd4;
        step();
        iWe = 1'b0;
        iEn = 2'b11;
        step(); step(); step();
        total++; if (oClk_out !== 2'b11) begin bad++; $display("FAIL sync_pre got=%b exp=11", oClk_out); end
        iSync = 1'b1;
        step();
        iSync = 1'b0;
        total++; if (oClk_out !== 2'b00 || oTick !== 2'b00) begin bad++; $display("FAIL sync_edge got=%b/%b exp=00/00", oClk_out, oTick); end
        for (int j = 1; j <= 12; j++) begin
            step();
            c0 = ((j % 6) >= 3); t0 = ((j % 6) == 0);
            c1 = ((j % 4) >= 2); t1 = ((j % 4) == 0);
            total++; if (oClk_out !== {c1, c0} || oTick !== {t1, t0})
            begin bad++; $display("FAIL sync_run j=%0d got=%b/%b exp=%b%b/%b%b", j, oClk_out, oTick, c1, c0, t1, t0); end
        end
    endtask

    task automatic test_write_at_wrap();
        logic c;
        logic t;
        for (int j = 0; j < 5; j++) step();
        iWe = 1'b1; iSel = 1'b0; iDiv = 8'd3;
        step();
        iWe = 1'b0;
        total++; if (oTick[0] !== 1'b1 || oPend[0] !== 1'b0) begin bad++; $display("FAIL wrap_write got=%b%b exp=10", oTick[0], oPend[0]); end
        for (int j = 1; j <= 6; j++) begin
            step();
            c = ((j % 3) >= 2);
            t = ((j % 3) == 0);
            total++; if (oClk_out[0] !== c || oTick[0] !== t || oPend[0] !== 1'b0)
            begin bad++; $display("FAIL div3 j=%0d got=%b%b%b exp=%b%b0", j, oClk_out[0], oTick[0], oPend[0], c, t); end
        end
    endtask

    task automatic test_reset_mid();
        logic c;
        logic t;
        iWe = 1'b1; iSel = 1'b0; iDiv = 8'd7;
        step();
        iWe = 1'b0;
        total++; if (oPend[0] !== 1'b1) begin bad++; $display("FAIL mid_pend got=%b exp=1", oPend[0]); end
        #1;
        iRst = 1'b0;
        #1;
        total++; if (oClk_out !== 2'b00 || oTick !== 2'b00 || oPend !== 2'b00)
        begin bad++; $display("FAIL mid_async got=%b/%b/%b exp=00/00/00", oClk_out, oTick, oPend); end
        #1;
        iRst = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            c = ((j % 4) >= 2);
            t = ((j % 4) == 0);
            total++; if (oClk_out !== {c, c} || oTick !== {t, t} || oPend !== 2'b00)
            begin bad++; $display("FAIL mid_restart j=%0d got=%b/%b/%b exp=%b%b/%b%b/00", j, oClk_out, oTick, oPend, c, c, t, t); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_div_change();
        test_small_div();
        test_sel_ignore();
        test_sync();
        test_write_at_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Multi-channel, run-time programmable clock divider; the successor to the fixed single-output divider.
- Each of NUM_CH channels divides iClk_in by its own divisor. Each channel produces a divided clock-enable-style square wave (oClk_out) and a one-cycle tick (oTick).
- Divisors are written through a simple register port and applied glitch-free at the channel's period boundary.
- A global sync input phase-aligns channels. The block feeds timers, display scanners and blink logic from the 1 MHz system clock.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 20, counter/divisor width in bits; must hold DEFAULT_DIV.
- DEFAULT_DIV, 1000000, divisor loaded into every channel at reset (1 MHz -> 1 Hz).
- SEL_W, 2, width of channel select; must satisfy 2^SEL_W >= NUM_CH.

Ports:
- iClk_in  input  1  system clock, rising-edge.
- iRst  input  1  asynchronous active-low reset.
- iEn  input  NUM_CH  per-channel run enable.
- iWe  input  1  divisor write strobe, one cycle.
- iSel  input  SEL_W  target channel for write.
- iDiv  input  CNT_W  divisor value to write.
- iSync  input  1  one-cycle phase-realign pulse for all enabled channels.
- oClk_out  output  NUM_CH  divided square wave per channel (registered).
- oTick  output  NUM_CH  one-cycle pulse per period per channel (registered).
- oPend  output  NUM_CH  1 while a written divisor is waiting to be applied.

Behaviour:
- Reset (iRst=0, async): cnt=0, active divisor N=DEFAULT_DIV, pending=DEFAULT_DIV, oClk_out=0, oTick=0, oPend=0 for all channels.
- Effective divisor: E = max(N,2); values 0 and 1 are treated as 2. Period = E input cycles. HI = E>>1.
- oClk_out is high while cnt >= E-HI, so each period starts low. Duty: N=2 gives 1 low/1 high; N=3 gives 2 low/1 high; even N gives 50%.
- Enabled channel, each rising edge:
  - cnt <= (cnt==E-1) ? 0 : cnt+1.
  - oClk_out <= value implied by cnt_next.
  - oTick <= (cnt==E-1), so oTick is high in the cycle cnt reads 0 after a wrap.
  - First tick after enable: E cycles after the enabling edge.
- Disabled channel (iEn[k]=0): cnt held 0, oClk_out=0, oTick=0. Pending is copied to N every cycle, so writes apply immediately and oPend=0.
- Write: iWe=1 with iSel<NUM_CH sets pending[iSel] <= iDiv and oPend[iSel] <= 1. iSel >= NUM_CH: write ignored, no state change.
- Apply on an enabled channel: at the wrap edge (cnt==E-1), N <= pending and oPend clears. The current period always completes with the old divisor; no runt pulses.
- Write and wrap on the same edge: iDiv bypasses pending, is applied as N for the next period, and oPend stays 0.
- Back-to-back writes before a wrap: the last write wins.
- Sync: iSync=1 forces every enabled channel to cnt<=0, oClk_out<=0, oTick<=0, and N <= pending (oPend clears). Disabled channels are unaffected.
- Sync and wrap on the same edge: sync wins, no tick that cycle.
- Sync and write on the same edge: the written value is applied immediately.
- Reset mid-period: outputs drop to reset values asynchronously. After release, counting restarts from cnt=0 with DEFAULT_DIV.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan (bench params NUM_CH=2, CNT_W=8, DEFAULT_DIV=4, SEL_W=1):
- Reset then iEn=2'b11 -> both oClk_out show 2 low/2 high, period 4 cycles; oTick pulses every 4th cycle; first tick 4 cycles after enable.
- Enabled ch0, write iDiv=5 mid-period (cnt=1) -> oPend[0]=1; current period still 4 cycles; next periods are 5 cycles (3 low/2 high); oPend[0] clears at the wrap.
- Write ch1 iDiv=0 and iDiv=1 -> both behave as divisor 2, oClk_out[1] toggles every cycle. Write iSel=1 with NUM_CH=1 build -> no effect.
- Run ch0 at 6 and ch1 at 4, pulse iSync -> both cnt=0 next cycle, no tick on that edge; rising edges coincide every 12 cycles.
- Write coinciding exactly with the wrap edge (iDiv=3) -> the next period is 3 cycles and oPend never asserts.
- Assert iRst=0 mid-period -> oClk_out, oTick and oPend go 0 without a clock edge; after release with iEn high, period is 4 again.
